// File: rtl/twiddle_mult_1st_fft.sv
// Stage-1 twiddle multiplier for the 64-point SDF FFT.
// Three-stage pipeline: index decode, quarter-wave ROM lookup, complex multiply with
// round/saturate. Indices that are a multiple of 16 rotate by swap/negate only.
// Also counts valid outputs and pulses frame_done on the last sample of each frame.
module twiddle_mult_1st_fft #(
    parameter int STAGE_NO = 1,
    parameter int NFFT     = 64,
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid_in,
    input  logic signed [DATA_W-1:0] data_re_in,
    input  logic signed [DATA_W-1:0] data_im_in,
    input  logic [5:0]               Twiddle_address,
    output logic                     data_valid_out,
    output logic signed [DATA_W-1:0] data_re_out,
    output logic signed [DATA_W-1:0] data_im_out,
    output logic                     frame_done
);
    localparam int STAGES = 3;
    localparam int CNT_W  = $clog2(NFFT);
    localparam int PW     = DATA_W + TW_W + 1;
    localparam int FRAC   = TW_W - 1;
    localparam logic signed [PW-1:0]     RND  = PW'(2**(FRAC-1));
    localparam logic signed [PW-1:0]     SMAX = PW'(2**(DATA_W-1) - 1);
    localparam logic signed [PW-1:0]     SMIN = PW'(-(2**(DATA_W-1)));
    localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]         LAST = CNT_W'(NFFT - 1);

    // Quarter-wave table: round(32767*cos(2*pi*i/64)), i = 0..16
    function automatic logic signed [TW_W-1:0] cos_rom(input logic [4:0] i);
        case (i)
            5'd0:    cos_rom = TW_W'(32767);
            5'd1:    cos_rom = TW_W'(32609);
            5'd2:    cos_rom = TW_W'(32137);
            5'd3:    cos_rom = TW_W'(31356);
            5'd4:    cos_rom = TW_W'(30273);
            5'd5:    cos_rom = TW_W'(28898);
            5'd6:    cos_rom = TW_W'(27245);
            5'd7:    cos_rom = TW_W'(25329);
            5'd8:    cos_rom = TW_W'(23170);
            5'd9:    cos_rom = TW_W'(20787);
            5'd10:   cos_rom = TW_W'(18204);
            5'd11:   cos_rom = TW_W'(15446);
            5'd12:   cos_rom = TW_W'(12539);
            5'd13:   cos_rom = TW_W'(9512);
            5'd14:   cos_rom = TW_W'(6393);
            5'd15:   cos_rom = TW_W'(3212);
            default: cos_rom = '0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [PW-1:0] v);
        if (v > SMAX)      sat_q = DMAX;
        else if (v < SMIN) sat_q = DMIN;
        else               sat_q = v[DATA_W-1:0];
    endfunction

    // Negation that maps the most negative value to the most positive one
    function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
        neg_sat = (x == DMIN) ? DMAX : -x;
    endfunction

    logic [STAGES:1]           vld_pipe;
    logic signed [DATA_W-1:0]  s1_re, s1_im, s2_re, s2_im;
    logic [1:0]                s1_q, s2_q;
    logic [3:0]                s1_r;
    logic                      s1_exact, s2_exact;
    logic signed [TW_W-1:0]    s2_c, s2_d;
    logic signed [TW_W-1:0]    rom_c, rom_d, tw_c, tw_d;
    logic signed [PW-1:0]      p_re, p_im;
    logic signed [DATA_W-1:0]  m_re, m_im, e_re, e_im;
    logic [CNT_W-1:0]          cnt;

    // Valid bits travel alongside the data; bubbles are just zeros here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[STAGES-1:1], data_valid_in};
    end

    // S1: split the index into quadrant and in-quadrant offset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_re <= '0; s1_im <= '0; s1_q <= '0; s1_r <= '0; s1_exact <= 1'b0;
        end else if (data_valid_in) begin
            s1_re    <= data_re_in;
            s1_im    <= data_im_in;
            s1_q     <= Twiddle_address[5:4];
            s1_r     <= Twiddle_address[3:0];
            s1_exact <= (Twiddle_address[3:0] == 4'd0);
        end
    end

    // Base twiddle for the offset, then rotate by -j once per quadrant
    always_comb begin
        rom_c = cos_rom({1'b0, s1_r});
        rom_d = -cos_rom(5'd16 - {1'b0, s1_r});
        case (s1_q)
            2'd0:    begin tw_c = rom_c;  tw_d = rom_d;  end
            2'd1:    begin tw_c = rom_d;  tw_d = -rom_c; end
            2'd2:    begin tw_c = -rom_c; tw_d = -rom_d; end
            default: begin tw_c = -rom_d; tw_d = rom_c;  end
        endcase
    end

    // S2: register the twiddle next to the sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_re <= '0; s2_im <= '0; s2_q <= '0; s2_exact <= 1'b0; s2_c <= '0; s2_d <= '0;
        end else if (vld_pipe[1]) begin
            s2_re    <= s1_re;
            s2_im    <= s1_im;
            s2_q     <= s1_q;
            s2_exact <= s1_exact;
            s2_c     <= tw_c;
            s2_d     <= tw_d;
        end
    end

    // Full-precision complex product, round half up, saturate; exact path by swap/negate
    always_comb begin
        p_re = PW'(s2_re) * PW'(s2_c) - PW'(s2_im) * PW'(s2_d);
        p_im = PW'(s2_re) * PW'(s2_d) + PW'(s2_im) * PW'(s2_c);
        m_re = sat_q((p_re + RND) >>> FRAC);
        m_im = sat_q((p_im + RND) >>> FRAC);
        case (s2_q)
            2'd0:    begin e_re = s2_re;          e_im = s2_im;          end
            2'd1:    begin e_re = s2_im;          e_im = neg_sat(s2_re); end
            2'd2:    begin e_re = neg_sat(s2_re); e_im = neg_sat(s2_im); end
            default: begin e_re = neg_sat(s2_im); e_im = s2_re;          end
        endcase
    end

    // S3: output register plus frame counter keyed to the outgoing valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_re_out <= '0;
            data_im_out <= '0;
            frame_done  <= 1'b0;
            cnt         <= '0;
        end else begin
            frame_done <= vld_pipe[2] && (cnt == LAST);
            if (vld_pipe[2]) begin
                data_re_out <= s2_exact ? e_re : m_re;
                data_im_out <= s2_exact ? e_im : m_im;
                cnt         <= cnt + CNT_W'(1);
            end
        end
    end

    assign data_valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_twiddle_mult_1st_fft.sv
// Bench for twiddle_mult_1st_fft: reset/flush check, directed vector table with
// latency checks, then two 64-sample frames against a trig-based reference model.
module tb_twiddle_mult_1st_fft;
    logic               clk = 1'b0;
    logic               rst;
    logic               dvi;
    logic signed [15:0] rei, imi;
    logic [5:0]         ta;
    logic               dvo;
    logic signed [15:0] reo, imo;
    logic               fd;

    int n_cmp = 0;
    int n_bad = 0;
    bit sb_on = 1'b0;
    int q_re[$];
    int q_im[$];
    int out_cnt = 0;
    int fd_cnt  = 0;

    typedef struct {int k; int re; int im; int ere; int eim;} vec_t;
    vec_t vt[11];

    always #5 clk = ~clk;

    twiddle_mult_1st_fft #(.STAGE_NO(1), .NFFT(64), .DATA_W(16), .TW_W(16)) dut (
        .clk(clk), .rst(rst),
        .data_valid_in(dvi), .data_re_in(rei), .data_im_in(imi), .Twiddle_address(ta),
        .data_valid_out(dvo), .data_re_out(reo), .data_im_out(imo), .frame_done(fd)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic int sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference: sample * W64^k, with exact unit rotations when k is a multiple of 16
    task automatic model(input int k, input int a, input int b, output int ore, output int oim);
        real    th;
        int     wr, wi;
        longint pr, pi;
        if (k % 16 == 0) begin
            case (k / 16)
                0:       begin ore = a;       oim = b;       end
                1:       begin ore = b;       oim = sat(-a); end
                2:       begin ore = sat(-a); oim = sat(-b); end
                default: begin ore = sat(-b); oim = a;       end
            endcase
        end else begin
            th = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
            wr = rnd(32767.0 * $cos(th));
            wi = -rnd(32767.0 * $sin(th));
            pr = longint'(a) * wr - longint'(b) * wi;
            pi = longint'(a) * wi + longint'(b) * wr;
            ore = sat((pr + 16384) >>> 15);
            oim = sat((pi + 16384) >>> 15);
        end
    endtask

    task automatic monitor();
        int er, ei;
        if (dvo) begin
            if (q_re.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else begin
                er = q_re.pop_front();
                ei = q_im.pop_front();
                chk("sb_re", reo, er);
                chk("sb_im", imo, ei);
            end
            out_cnt++;
            chk("sb_frame_done", fd, (out_cnt % 64 == 0) ? 1 : 0);
        end else begin
            chk("sb_frame_done_idle", fd, 0);
        end
        if (fd) fd_cnt++;
    endtask

    // One cycle: sample outputs on the falling edge, then present the next input
    task automatic step(input bit v, input int k, input int a, input int b);
        int er, ei;
        @(negedge clk);
        if (sb_on) monitor();
        dvi = v;
        ta  = 6'(k);
        rei = 16'(a);
        imi = 16'(b);
        if (v && sb_on) begin
            model(k, a, b, er, ei);
            q_re.push_back(er);
            q_im.push_back(ei);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0; dvi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic signed [15:0] r16a, r16b;
        int gap, kk;

        vt[0]  = '{0,  1000,   -2000,  1000,   -2000};
        vt[1]  = '{16, 1000,   -2000,  -2000,  -1000};
        vt[2]  = '{32, 1000,   -2000,  -1000,  2000};
        vt[3]  = '{48, 1000,   -2000,  2000,   1000};
        vt[4]  = '{8,  16384,  0,      11585,  -11585};
        vt[5]  = '{1,  32767,  0,      32608,  -3212};
        vt[6]  = '{32, -32768, -32768, 32767,  32767};
        vt[7]  = '{16, -32768, 5,      5,      32767};
        vt[8]  = '{8,  -32768, -32768, -32768, 0};
        vt[9]  = '{4,  1000,   0,      924,    -383};
        vt[10] = '{40, 0,      1000,   -707,   -707};

        rst = 1'b0; dvi = 1'b0; rei = '0; imi = '0; ta = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", dvo, 0);
        chk("reset_re", reo, 0);
        chk("reset_im", imo, 0);
        chk("reset_frame_done", fd, 0);
        rst = 1'b1;

        // Two samples in flight, then reset: nothing may emerge afterwards
        step(1, 0, 111, 222);
        step(1, 20, 333, 444);
        @(negedge clk);
        rst = 1'b0; dvi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_valid", dvo, 0);
            chk("flush_re", reo, 0);
            chk("flush_im", imo, 0);
        end

        // Directed vectors, each checked for 3-cycle latency
        for (int i = 0; i < 11; i++) begin
            step(1, vt[i].k, vt[i].re, vt[i].im);
            step(0, 0, 0, 0);
            chk("lat_c1_valid", dvo, 0);
            step(0, 0, 0, 0);
            chk("lat_c2_valid", dvo, 0);
            step(0, 0, 0, 0);
            chk("lat_c3_valid", dvo, 1);
            chk($sformatf("vec%0d_re", i), reo, vt[i].ere);
            chk($sformatf("vec%0d_im", i), imo, vt[i].eim);
            chk("vec_frame_done", fd, 0);
            step(0, 0, 0, 0);
            chk("lat_c4_valid", dvo, 0);
        end

        // Frame 1: stage-1 index order with random gaps; frame 2: back-to-back random k
        rst_pulse();
        sb_on = 1'b1;
        for (int n = 0; n < 64; n++) begin
            r16a = 16'($urandom); r16b = 16'($urandom);
            if (n == 5)  begin r16a = 16'sh8000; r16b = 16'sh8000; end
            if (n == 40) begin r16a = 16'sh7fff; r16b = 16'sh8000; end
            kk = (n < 32) ? 0 : n - 32;
            step(1, kk, int'(r16a), int'(r16b));
            gap = $urandom_range(0, 3);
            repeat (gap) step(0, 0, 0, 0);
        end
        for (int n = 0; n < 64; n++) begin
            r16a = 16'($urandom); r16b = 16'($urandom);
            step(1, $urandom_range(0, 63), int'(r16a), int'(r16b));
        end
        for (int i = 0; i < 16 && q_re.size() > 0; i++) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("drain_pending", q_re.size(), 0);
        chk("output_count", out_cnt, 128);
        chk("frame_done_count", fd_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
